axil_regfile_gen: RTL and testbench
===================================

// Module: axil_regfile_gen
// PURPOSE
//  Parametrised AXI4-Lite slave register file: N_CTRL read/write control registers and N_STAT read-only status inputs.
//  Independent AW/W channel acceptance; SLVERR on unmapped, unaligned or illegal accesses.
//  Per-register write/read strobes go to PL logic; sits between the PS/host AXI-Lite master and PL datapath control.
// PARAMETERS
//  ADDR_BITS  32           AXI address width
//  DATA_BITS  32           AXI data width (32 or 64); DATA_BYTES=DATA_BITS/8
//  N_CTRL     4            number of RW control registers (1..64)
//  N_STAT     4            number of RO status registers (1..64)
//  CTRL_BASE  'h000        byte address of ctrl[0]; ctrl[i] at CTRL_BASE+i*DATA_BYTES
//  STAT_BASE  'h100        byte address of stat[0]; stat[i] at STAT_BASE+i*DATA_BYTES
//  CTRL_RST   0            N_CTRL*DATA_BITS packed reset values, ctrl[i]=CTRL_RST[i*DATA_BITS+:DATA_BITS]
//  IRQ_BASE   'h200        IRQ block base (used only with AXIL_RF_IRQ_EN)
// PORTS
//  s_axi_aclk     in   1                  clock
//  s_axi_aresetn  in   1                  async reset, active low
//  s_axi_aw*/w*/b*/ar*/r*  -              AXI4-Lite slave: awaddr,awvalid,awready,wdata,wstrb,wvalid,wready,
//                                         bresp[1:0],bvalid,bready,araddr,arvalid,arready,rdata,rresp[1:0],rvalid,rready
//  ctrl_o         out  N_CTRL*DATA_BITS   packed control register contents
//  ctrl_wr_o      out  N_CTRL             1-cycle pulse, ctrl[i] written (any strobe)
//  stat_i         in   N_STAT*DATA_BITS   packed status values, sampled on read
//  stat_rd_o      out  N_STAT             1-cycle pulse, stat[i] read accepted
//  irq_src_i      in   DATA_BITS          interrupt sources (AXIL_RF_IRQ_EN only)
//  irq_o          out  1                  level interrupt (AXIL_RF_IRQ_EN only)
// BEHAVIOUR
//  Reset s_axi_aresetn: asynchronous, active-low. Clock s_axi_aclk.
//  Reset values: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; ctrl_o=CTRL_RST; ctrl_wr_o=stat_rd_o=0; irq_o=0.
//  Reset mid-transaction discards pending address/data/response.
//  Decode: hit when addr in region and addr[log2(DATA_BYTES)-1:0]==0; index=(addr-BASE)>>log2(DATA_BYTES). All else unmapped.
//  Write channel, one outstanding write:
//   - AW and W accepted independently; each ready drops the cycle after its own handshake. Either order or same cycle.
//   - Edge after both are held: commit.
//     ctrl hit: bytes with wstrb=1 updated; ctrl_wr_o[i]=1 for 1 cycle; bresp=OKAY.
//     stat hit or unmapped: no register change, no pulse; bresp=SLVERR (2'b10).
//   - bvalid rises on the commit edge and holds with stable bresp until bready.
//   - awready/wready reassert on the edge after the B handshake. B-to-next-AW minimum 1 cycle.
//   - wstrb=0 on a ctrl hit: OKAY, register unchanged, ctrl_wr_o still pulses.
//  Read channel, one outstanding read, independent of write:
//   - AR handshake at edge E0: araddr latched, arready=0.
//   - At E1: rdata<=ctrl[i] / stat_i[i] / 0 (unmapped); rvalid=1; rresp=OKAY, or SLVERR if unmapped.
//     stat_rd_o[i] pulses during the cycle after E1 for a stat hit.
//   - rdata/rresp held stable while rvalid && !rready. arready reasserts on the edge after the R handshake.
//  Read and write commit to the same ctrl register on the same edge: read returns the pre-write value.
//  Back-pressure (bready/rready low indefinitely): the channel stalls; the other channel continues.
// CONFIGURATION
//  `define AXIL_RF_IRQ_EN: adds irq_src_i, irq_o and two registers:
//   - IRQ_STATUS at IRQ_BASE: sticky; bit set on 0->1 edge of registered irq_src_i; W1C by strobed bytes.
//     A set and a clear on the same edge: the set wins.
//   - IRQ_ENABLE at IRQ_BASE+DATA_BYTES: RW, reset 0.
//   - irq_o registered: irq_o = |(IRQ_STATUS & IRQ_ENABLE), 1 cycle after the status/enable update.
//  Without the macro: the ports are absent and the IRQ addresses are unmapped (SLVERR).
// TESTING
//  1. Reset, then read ctrl[0..N_CTRL-1] -> CTRL_RST values, OKAY; read 'h0FC -> rdata=0, SLVERR.
//  2. AW 'h004 three cycles before W 'hA5A5_1234, wstrb 4'b0101 (ctrl[1] was 0) -> ctrl[1]='h00A5_0034;
//     ctrl_wr_o[1] 1 cycle; bvalid 1 edge after W; bresp=OKAY.
//  3. W before AW, then bready held low 5 cycles -> bvalid held, awready=wready=0 until B handshake, then 1 next cycle.
//  4. stat_i[2]='hDEAD_BEEF, read 'h108 with rready low 3 cycles -> rvalid 1 edge after AR;
//     rdata stable 'hDEADBEEF; stat_rd_o[2] 1 pulse. Write 'h108 -> SLVERR, no change.
//  5. Same-edge write 'h0000_0001 and read of ctrl[0] (was 0) -> rdata=0; a following read returns 1.
//  6. IRQ_EN: enable=1, pulse irq_src_i[0] -> status bit0=1, irq_o=1;
//     W1C 'h1 while the source pulses again -> bit stays 1; clear alone -> irq_o=0.

Source files
------------

// File: rtl/axil_regfile_gen.sv
// ---------------------------------------------------------------------------
// axil_regfile_gen
//   AXI4-Lite slave register file: N_CTRL read/write control registers and
//   N_STAT read-only status inputs. AW and W are accepted independently, with
//   one write and one read outstanding. Unmapped, unaligned or illegal
//   accesses return SLVERR. Per-register write/read strobes go to PL logic.
//
// Optional feature macro: AXIL_RF_IRQ_EN
//   Adds irq_src_i/irq_o, IRQ_STATUS (sticky, W1C) at IRQ_BASE and
//   IRQ_ENABLE at IRQ_BASE+DATA_BYTES. Without it those addresses are
//   unmapped.
//
// Ports
//   s_axi_aclk, s_axi_aresetn  clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*     AXI4-Lite slave interface
//   ctrl_o     [N_CTRL*DATA_BITS]  packed control register contents
//   ctrl_wr_o  [N_CTRL]            1-cycle pulse when ctrl[i] is written
//   stat_i     [N_STAT*DATA_BITS]  packed status values, sampled on read
//   stat_rd_o  [N_STAT]            1-cycle pulse when stat[i] read is returned
//   irq_src_i  [DATA_BITS]         interrupt sources (AXIL_RF_IRQ_EN only)
//   irq_o                          level interrupt   (AXIL_RF_IRQ_EN only)
// ---------------------------------------------------------------------------
module axil_regfile_gen #(
    parameter int                          ADDR_BITS = 32,
    parameter int                          DATA_BITS = 32,
    parameter int                          N_CTRL    = 4,
    parameter int                          N_STAT    = 4,
    parameter logic [ADDR_BITS-1:0]        CTRL_BASE = 'h000,
    parameter logic [ADDR_BITS-1:0]        STAT_BASE = 'h100,
    parameter logic [N_CTRL*DATA_BITS-1:0] CTRL_RST  = '0,
    parameter logic [ADDR_BITS-1:0]        IRQ_BASE  = 'h200
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [ADDR_BITS-1:0]        s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_BITS-1:0]        s_axi_wdata,
    input  logic [DATA_BITS/8-1:0]      s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_BITS-1:0]        s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_BITS-1:0]        s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [N_CTRL*DATA_BITS-1:0] ctrl_o,
    output logic [N_CTRL-1:0]           ctrl_wr_o,
    input  logic [N_STAT*DATA_BITS-1:0] stat_i,
    output logic [N_STAT-1:0]           stat_rd_o
`ifdef AXIL_RF_IRQ_EN
    ,
    input  logic [DATA_BITS-1:0]        irq_src_i,
    output logic                        irq_o
`endif
);

    localparam int DATA_BYTES = DATA_BITS / 8;
    localparam int ADDR_LSB   = $clog2(DATA_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_RF_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef enum logic [2:0] {K_MISS, K_CTRL, K_STAT, K_IRQ_STAT, K_IRQ_EN} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [6:0] idx;
    } dec_t;

    // Region decode; anything outside a region or not word-aligned is a miss.
    // Offsets are unsigned, so an address below a base wraps large and misses.
    function automatic dec_t decode(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS-1:0] c_off;
        logic [ADDR_BITS-1:0] s_off;
        logic [ADDR_BITS-1:0] i_off;
        dec_t d;
        d.kind = K_MISS;
        d.idx  = '0;
        c_off  = addr - CTRL_BASE;
        s_off  = addr - STAT_BASE;
        i_off  = addr - IRQ_BASE;
        if (addr[ADDR_LSB-1:0] == '0) begin
            if (c_off < ADDR_BITS'(N_CTRL * DATA_BYTES)) begin
                d.kind = K_CTRL;
                d.idx  = 7'(c_off >> ADDR_LSB);
            end else if (s_off < ADDR_BITS'(N_STAT * DATA_BYTES)) begin
                d.kind = K_STAT;
                d.idx  = 7'(s_off >> ADDR_LSB);
            end else if (IRQ_ON && i_off == '0) begin
                d.kind = K_IRQ_STAT;
            end else if (IRQ_ON && i_off == ADDR_BITS'(DATA_BYTES)) begin
                d.kind = K_IRQ_EN;
            end
        end
        return d;
    endfunction

    logic [DATA_BITS-1:0]  ctrl_q [N_CTRL];
    logic [ADDR_BITS-1:0]  aw_addr_q;
    logic [DATA_BITS-1:0]  w_data_q;
    logic [DATA_BYTES-1:0] w_strb_q;
    logic [ADDR_BITS-1:0]  ar_addr_q;
    dec_t                  wr_dec;
    dec_t                  rd_dec;
    logic                  wr_commit;
    logic                  rd_load;
    logic [DATA_BITS-1:0]  rd_data;
    logic [1:0]            rd_resp;
    logic [N_STAT-1:0]     rd_stat;

`ifdef AXIL_RF_IRQ_EN
    logic [DATA_BITS-1:0]  irq_src_q;
    logic [DATA_BITS-1:0]  irq_src_qq;
    logic [DATA_BITS-1:0]  irq_status_q;
    logic [DATA_BITS-1:0]  irq_en_q;
    logic [DATA_BITS-1:0]  irq_set;
    logic [DATA_BITS-1:0]  irq_clr;
`endif

    for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_o
        assign ctrl_o[g*DATA_BITS +: DATA_BITS] = ctrl_q[g];
    end

    assign wr_dec = decode(aw_addr_q);
    assign rd_dec = decode(ar_addr_q);
    // Both halves held (both readies low) and no response pending yet.
    assign wr_commit = !s_axi_awready && !s_axi_wready && !s_axi_bvalid;
    // Address held and data not yet returned.
    assign rd_load   = !s_axi_arready && !s_axi_rvalid;

    // Read data/response mux.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        rd_stat = '0;
        case (rd_dec.kind)
            K_CTRL: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < N_CTRL; i++)
                    if (rd_dec.idx == 7'(i)) rd_data = ctrl_q[i];
            end
            K_STAT: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < N_STAT; i++)
                    if (rd_dec.idx == 7'(i)) begin
                        rd_data    = stat_i[i*DATA_BITS +: DATA_BITS];
                        rd_stat[i] = 1'b1;
                    end
            end
`ifdef AXIL_RF_IRQ_EN
            K_IRQ_STAT: begin
                rd_resp = RESP_OKAY;
                rd_data = irq_status_q;
            end
            K_IRQ_EN: begin
                rd_resp = RESP_OKAY;
                rd_data = irq_en_q;
            end
`endif
            default: ;
        endcase
    end

`ifdef AXIL_RF_IRQ_EN
    // Rising edge of the registered sources sets status; a committed W1C
    // clears strobed bytes. Set is OR-ed in after the clear so it wins.
    always_comb begin
        irq_set = irq_src_q & ~irq_src_qq;
        irq_clr = '0;
        if (wr_commit && wr_dec.kind == K_IRQ_STAT)
            for (int b = 0; b < DATA_BYTES; b++)
                if (w_strb_q[b]) irq_clr[8*b +: 8] = w_data_q[8*b +: 8];
    end
`endif

    // Write channel and register bank.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            ctrl_wr_o     <= '0;
            // NOTE: the control bank is a few flops, not a RAM, so each entry takes its reset value.
            for (int i = 0; i < N_CTRL; i++)
                ctrl_q[i] <= CTRL_RST[i*DATA_BITS +: DATA_BITS];
`ifdef AXIL_RF_IRQ_EN
            irq_src_q    <= '0;
            irq_src_qq   <= '0;
            irq_status_q <= '0;
            irq_en_q     <= '0;
            irq_o        <= 1'b0;
`endif
        end else begin
            ctrl_wr_o <= '0;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_addr_q     <= s_axi_awaddr;
                s_axi_awready <= 1'b0;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_data_q     <= s_axi_wdata;
                w_strb_q     <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end
            if (wr_commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= RESP_SLVERR;
                case (wr_dec.kind)
                    K_CTRL: begin
                        s_axi_bresp <= RESP_OKAY;
                        for (int i = 0; i < N_CTRL; i++)
                            if (wr_dec.idx == 7'(i)) begin
                                ctrl_wr_o[i] <= 1'b1;
                                // NOTE: non-blocking update, so a read loading on this edge returns the old value.
                                for (int b = 0; b < DATA_BYTES; b++)
                                    if (w_strb_q[b]) ctrl_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                            end
                    end
`ifdef AXIL_RF_IRQ_EN
                    K_IRQ_STAT: s_axi_bresp <= RESP_OKAY;
                    K_IRQ_EN: begin
                        s_axi_bresp <= RESP_OKAY;
                        for (int b = 0; b < DATA_BYTES; b++)
                            if (w_strb_q[b]) irq_en_q[8*b +: 8] <= w_data_q[8*b +: 8];
                    end
`endif
                    default: ;
                endcase
            end
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid  <= 1'b0;
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
`ifdef AXIL_RF_IRQ_EN
            irq_src_q    <= irq_src_i;
            irq_src_qq   <= irq_src_q;
            irq_status_q <= (irq_status_q & ~irq_clr) | irq_set;
            irq_o        <= |(irq_status_q & irq_en_q);
`endif
        end
    end

    // Read channel: latch address, load data one edge later, hold until R handshake.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            ar_addr_q     <= '0;
            stat_rd_o     <= '0;
        end else begin
            stat_rd_o <= '0;
            if (s_axi_arvalid && s_axi_arready) begin
                ar_addr_q     <= s_axi_araddr;
                s_axi_arready <= 1'b0;
            end
            if (rd_load) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_resp;
                stat_rd_o    <= rd_stat;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid  <= 1'b0;
                s_axi_arready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_regfile_gen.sv
// ---------------------------------------------------------------------------
// tb_axil_regfile_gen
//   Self-checking bench for axil_regfile_gen (default parameters, non-zero
//   reset values on ctrl[2]/ctrl[3]). Expected B and R responses are queued
//   when a transaction is issued and compared by monitors at the handshake.
//   The IRQ scenario is compiled in when AXIL_RF_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module tb_axil_regfile_gen;

    localparam logic [127:0] TB_CTRL_RST = {32'hCAFE_0003, 32'h1111_2222, 32'h0, 32'h0};
    localparam logic [1:0]   OKAY   = 2'b00;
    localparam logic [1:0]   SLVERR = 2'b10;

    logic         s_axi_aclk = 1'b0;
    logic         s_axi_aresetn;
    logic [31:0]  s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [31:0]  s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [127:0] ctrl_o;
    logic [3:0]   ctrl_wr_o;
    logic [127:0] stat_i;
    logic [3:0]   stat_rd_o;
`ifdef AXIL_RF_IRQ_EN
    logic [31:0]  irq_src_i;
    logic         irq_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]   wr_q [$];
    logic [33:0]  rd_q [$];
    logic [127:0] exp_ctrl;

    always #5 s_axi_aclk = ~s_axi_aclk;

    axil_regfile_gen #(.CTRL_RST(TB_CTRL_RST)) dut (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .ctrl_o       (ctrl_o),
        .ctrl_wr_o    (ctrl_wr_o),
        .stat_i       (stat_i),
`ifdef AXIL_RF_IRQ_EN
        .irq_src_i    (irq_src_i),
        .irq_o        (irq_o),
`endif
        .stat_rd_o    (stat_rd_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    // Scoreboard monitors: sampled on the falling edge, the handshake completes on the next rising edge.
    always @(negedge s_axi_aclk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (s_axi_aresetn === 1'b1 && s_axi_bvalid && s_axi_bready) begin
            if (wr_q.size() == 0) check("b_unexpected", 128'(1), 128'(0));
            else begin
                eb = wr_q.pop_front();
                check("bresp", 128'(s_axi_bresp), 128'(eb));
            end
        end
        if (s_axi_aresetn === 1'b1 && s_axi_rvalid && s_axi_rready) begin
            if (rd_q.size() == 0) check("r_unexpected", 128'(1), 128'(0));
            else begin
                er = rd_q.pop_front();
                check("rdata", 128'(s_axi_rdata), 128'(er[33:2]));
                check("rresp", 128'(s_axi_rresp), 128'(er[1:0]));
            end
        end
    end

    // lead > 0: AW handshakes lead W by that many cycles; lead < 0: W leads AW.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input logic [3:0] exp_pulse,
                             input int lead, input int bstall);
        wr_q.push_back(exp_resp);
        fork
            begin
                int n = 0;
                if (lead < 0) repeat (-lead) tick();
                s_axi_awaddr  = addr;
                s_axi_awvalid = 1'b1;
                @(negedge s_axi_aclk);
                while (!s_axi_awready && n < 50) begin @(negedge s_axi_aclk); n++; end
                if (n >= 50) check("aw_timeout", 128'(0), 128'(1));
                tick();
                s_axi_awvalid = 1'b0;
                check("awready_drop", 128'(s_axi_awready), 128'(0));
            end
            begin
                int n = 0;
                if (lead > 0) repeat (lead) tick();
                s_axi_wdata  = data;
                s_axi_wstrb  = strb;
                s_axi_wvalid = 1'b1;
                @(negedge s_axi_aclk);
                while (!s_axi_wready && n < 50) begin @(negedge s_axi_aclk); n++; end
                if (n >= 50) check("w_timeout", 128'(0), 128'(1));
                tick();
                s_axi_wvalid = 1'b0;
                check("wready_drop", 128'(s_axi_wready), 128'(0));
            end
        join
        check("bvalid_early", 128'(s_axi_bvalid), 128'(0));
        tick();
        check("bvalid_latency", 128'(s_axi_bvalid), 128'(1));
        check("ctrl_wr_pulse", 128'(ctrl_wr_o), 128'(exp_pulse));
        repeat (bstall) begin
            tick();
            check("b_hold_valid", 128'(s_axi_bvalid), 128'(1));
            check("b_hold_resp", 128'(s_axi_bresp), 128'(exp_resp));
            check("b_hold_awready", 128'(s_axi_awready), 128'(0));
            check("b_hold_wready", 128'(s_axi_wready), 128'(0));
            check("ctrl_wr_clear", 128'(ctrl_wr_o), 128'(0));
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bvalid_drop", 128'(s_axi_bvalid), 128'(0));
        check("awready_back", 128'(s_axi_awready), 128'(1));
        check("wready_back", 128'(s_axi_wready), 128'(1));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input logic [3:0] exp_rd, input int stall);
        int n = 0;
        rd_q.push_back({exp_data, exp_resp});
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        @(negedge s_axi_aclk);
        while (!s_axi_arready && n < 50) begin @(negedge s_axi_aclk); n++; end
        if (n >= 50) check("ar_timeout", 128'(0), 128'(1));
        tick();
        s_axi_arvalid = 1'b0;
        check("arready_drop", 128'(s_axi_arready), 128'(0));
        check("rvalid_early", 128'(s_axi_rvalid), 128'(0));
        tick();
        check("rvalid_latency", 128'(s_axi_rvalid), 128'(1));
        check("stat_rd_pulse", 128'(stat_rd_o), 128'(exp_rd));
        repeat (stall) begin
            tick();
            check("r_hold_valid", 128'(s_axi_rvalid), 128'(1));
            check("r_hold_data", 128'(s_axi_rdata), 128'(exp_data));
            check("stat_rd_clear", 128'(stat_rd_o), 128'(0));
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("rvalid_drop", 128'(s_axi_rvalid), 128'(0));
        check("arready_back", 128'(s_axi_arready), 128'(1));
        check("stat_rd_idle", 128'(stat_rd_o), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_axi_aresetn = 1'b0;
        s_axi_awaddr  = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        stat_i   = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h5A5A_0000};
        exp_ctrl = TB_CTRL_RST;
`ifdef AXIL_RF_IRQ_EN
        irq_src_i = '0;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_awready", 128'(s_axi_awready), 128'(1));
        check("rst_wready", 128'(s_axi_wready), 128'(1));
        check("rst_arready", 128'(s_axi_arready), 128'(1));
        check("rst_bvalid", 128'(s_axi_bvalid), 128'(0));
        check("rst_rvalid", 128'(s_axi_rvalid), 128'(0));
        check("rst_bresp", 128'(s_axi_bresp), 128'(0));
        check("rst_rresp", 128'(s_axi_rresp), 128'(0));
        check("rst_rdata", 128'(s_axi_rdata), 128'(0));
        check("rst_ctrl_o", ctrl_o, TB_CTRL_RST);
        check("rst_ctrl_wr", 128'(ctrl_wr_o), 128'(0));
        check("rst_stat_rd", 128'(stat_rd_o), 128'(0));
        s_axi_aresetn = 1'b1;
        repeat (2) tick();

        // Reset values read back, then unmapped / unaligned reads
        for (int i = 0; i < 4; i++)
            axi_read(32'(i * 4), exp_ctrl[i*32 +: 32], OKAY, 4'b0000, 0);
        axi_read(32'h0FC, 32'h0, SLVERR, 4'b0000, 0);
        axi_read(32'h002, 32'h0, SLVERR, 4'b0000, 0);
        axi_read(32'h110, 32'h0, SLVERR, 4'b0000, 0);
`ifndef AXIL_RF_IRQ_EN
        axi_read(32'h200, 32'h0, SLVERR, 4'b0000, 0);
`endif

        // AW three cycles ahead of W, partial strobes
        axi_write(32'h004, 32'hA5A5_1234, 4'b0101, OKAY, 4'b0010, 3, 0);
        exp_ctrl[63:32] = 32'h00A5_0034;
        check("ctrl1_strobed", ctrl_o, exp_ctrl);

        // W ahead of AW, B back-pressured for 5 cycles
        axi_write(32'h00C, 32'h1234_5678, 4'b1111, OKAY, 4'b1000, -2, 5);
        exp_ctrl[127:96] = 32'h1234_5678;
        check("ctrl3_written", ctrl_o, exp_ctrl);

        // Zero strobes: OKAY, pulse, no change
        axi_write(32'h008, 32'hFFFF_FFFF, 4'b0000, OKAY, 4'b0100, 0, 0);
        check("ctrl2_nostrb", ctrl_o, exp_ctrl);

        // Status read with R back-pressure, then illegal writes
        stat_i[95:64] = 32'hDEAD_BEEF;
        axi_read(32'h108, 32'hDEAD_BEEF, OKAY, 4'b0100, 3);
        axi_read(32'h100, 32'h5A5A_0000, OKAY, 4'b0001, 0);
        axi_write(32'h108, 32'h0000_0001, 4'b1111, SLVERR, 4'b0000, 0, 0);
        axi_write(32'h0FC, 32'h0000_0001, 4'b1111, SLVERR, 4'b0000, 1, 0);
        axi_write(32'h006, 32'h0000_0001, 4'b1111, SLVERR, 4'b0000, 0, 2);
        check("ctrl_after_slverr", ctrl_o, exp_ctrl);

        // Same-edge read and write of ctrl[0]: read sees the old value
        fork
            axi_write(32'h000, 32'h0000_0001, 4'b1111, OKAY, 4'b0001, 0, 0);
            axi_read(32'h000, 32'h0, OKAY, 4'b0000, 0);
        join
        exp_ctrl[31:0] = 32'h1;
        axi_read(32'h000, 32'h1, OKAY, 4'b0000, 0);

        // Write completes while a read is stalled
        fork
            axi_read(32'h004, 32'h00A5_0034, OKAY, 4'b0000, 8);
            axi_write(32'h000, 32'h0000_0002, 4'b1111, OKAY, 4'b0001, 0, 0);
        join
        exp_ctrl[31:0] = 32'h2;
        check("ctrl_final", ctrl_o, exp_ctrl);

`ifdef AXIL_RF_IRQ_EN
        axi_write(32'h204, 32'h1, 4'b1111, OKAY, 4'b0000, 0, 0);
        irq_src_i[0] = 1'b1;
        tick();
        irq_src_i[0] = 1'b0;
        repeat (4) tick();
        check("irq_set", 128'(irq_o), 128'(1));
        axi_read(32'h200, 32'h1, OKAY, 4'b0000, 0);
        // Clear commits on the same edge the second source edge sets the bit
        fork
            axi_write(32'h200, 32'h1, 4'b1111, OKAY, 4'b0000, 0, 0);
            begin
                irq_src_i[0] = 1'b1;
                tick();
                irq_src_i[0] = 1'b0;
            end
        join
        repeat (3) tick();
        check("irq_set_wins", 128'(irq_o), 128'(1));
        axi_read(32'h200, 32'h1, OKAY, 4'b0000, 0);
        axi_write(32'h200, 32'h1, 4'b1111, OKAY, 4'b0000, 0, 0);
        repeat (3) tick();
        check("irq_cleared", 128'(irq_o), 128'(0));
        axi_read(32'h200, 32'h0, OKAY, 4'b0000, 0);
        axi_read(32'h204, 32'h1, OKAY, 4'b0000, 0);
`endif

        repeat (2) tick();
        check("wr_q_empty", 128'(wr_q.size()), 128'(0));
        check("rd_q_empty", 128'(rd_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
